// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receiver with start-glitch rejection and framing check.
// Define UART_RX_PARITY_EN for 8E1 framing with parity_err; otherwise 8N1 and parity_err=0.
module uart_rx_core #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBrk} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBrk} state_e;
`endif

  state_e           state_q;
  logic             rx_meta_q;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt_q;
  logic [OS_W-1:0]  os_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shreg_q;
  logic             tick;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q;
`endif

  // Two-flop synchroniser; idles at the line's mark level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  assign tick = (div_cnt_q == DIV_LAST);

  // Held at zero while idle so the first tick lands DIV cycles after start detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q <= '0;
    end else if (state_q == StIdle || tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          busy <= 1'b0;
          if (!rx_s) begin
            state_q  <= StStart;
            os_cnt_q <= '0;
            busy     <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
          end
        end
        StStart: begin
          if (tick) begin
            if (os_cnt_q == OS_MID) begin
              os_cnt_q <= '0;
              if (!rx_s) begin
                state_q   <= StData;
                bit_cnt_q <= '0;
              end else begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
        StData: begin
          if (tick) begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q  <= '0;
              shreg_q   <= {rx_s, shreg_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= StParity;
`else
                state_q <= StStop;
`endif
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tick) begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q  <= '0;
              par_bad_q <= ^{shreg_q, rx_s};
              state_q   <= StStop;
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
`endif
        StStop: begin
          if (tick) begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q <= '0;
              if (rx_s) begin
                // Leaving mid-stop-bit lets a zero-gap next start edge be caught.
                state_q <= StIdle;
                busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                if (par_bad_q) begin
                  parity_err <= 1'b1;
                end else begin
                  data  <= shreg_q;
                  valid <= 1'b1;
                end
`else
                data  <= shreg_q;
                valid <= 1'b1;
`endif
              end else begin
                frame_err <= 1'b1;
                state_q   <= StBrk;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
        StBrk: begin
          if (rx_s) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
